// File: rtl/pll_acq_ctrl.sv
// pll_acq_ctrl: PFD pulse-width measurement, VCO band search and lock sequencer.
// Define PLL_ACQ_STATS_EN to add the lock_loss_cnt and last_err outputs.
module pll_acq_ctrl #(
  parameter int CNT_W      = 12,
  parameter int BAND_W     = 4,
  parameter int BAND_INIT  = 8,
  parameter int COARSE_THR = 64,
  parameter int SETTLE_PER = 4,
  parameter int COARSE_OK  = 3,
  parameter int LOCK_THR   = 4,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_THR = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              ref_in,
  input  logic              up,
  input  logic              down,
  output logic [BAND_W-1:0] band,
  output logic              cp_en,
  output logic              lock,
  output logic              unlock_evt,
  output logic              band_sat,
`ifdef PLL_ACQ_STATS_EN
  output logic [15:0]       lock_loss_cnt,
  output logic [CNT_W-1:0]  last_err,
`endif
  output logic              fault
);

  localparam int SET_W  = $clog2(SETTLE_PER + 1);
  localparam int OK_W   = $clog2(COARSE_OK + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [BAND_W-1:0] BAND_RST = BAND_W'(BAND_INIT);
  localparam logic [BAND_W-1:0] BAND_MAX = '1;
  localparam logic [CNT_W-1:0]  CTHR     = CNT_W'(COARSE_THR);
  localparam logic [CNT_W-1:0]  LTHR     = CNT_W'(LOCK_THR);
  localparam logic [CNT_W-1:0]  UTHR     = CNT_W'(UNLOCK_THR);
  localparam logic [SET_W-1:0]  SET_V    = SET_W'(SETTLE_PER);
  localparam logic [OK_W-1:0]   OK_V     = OK_W'(COARSE_OK);
  localparam logic [GOOD_W-1:0] GOOD_V   = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_V    = BAD_W'(UNLOCK_CNT);
  localparam logic [TO_W-1:0]   TO_V     = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COARSE,
    S_FINE,
    S_LOCKED,
    S_FAULT
  } state_t;

  logic ref_s1_q, ref_s2_q, ref_s3_q;
  logic up_s1_q, up_s2_q;
  logic dn_s1_q, dn_s2_q;
  logic start_q;
  logic eval_q;

  logic [CNT_W-1:0] up_cnt_q, dn_cnt_q;
  logic [CNT_W-1:0] up_w_q, dn_w_q;
  logic [CNT_W-1:0] up_nxt, dn_nxt;
  logic [CNT_W-1:0] err;

  state_t            state_q, state_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic              sat_q, sat_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [OK_W-1:0]   ok_q, ok_d, ok_inc;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic [BAD_W-1:0]  bad_q, bad_d, bad_inc;
  logic [TO_W-1:0]   to_q, to_d, to_inc;
  logic              unlock_q, unlock_d;

  logic bnd;
  logic start_rise;
  logic active;
  logic settling, step_up, step_dn;
  logic up_big, dn_big;

  assign bnd        = ref_s2_q & ~ref_s3_q;
  assign start_rise = start & ~start_q;
  assign active     = (state_q == S_COARSE) ||
                      (state_q == S_FINE) ||
                      (state_q == S_LOCKED);

  assign up_nxt = (up_s2_q && up_cnt_q != '1) ?
                  up_cnt_q + 1'b1 : up_cnt_q;
  assign dn_nxt = (dn_s2_q && dn_cnt_q != '1) ?
                  dn_cnt_q + 1'b1 : dn_cnt_q;

  assign err = (up_w_q > dn_w_q) ? up_w_q : dn_w_q;

  assign up_big   = up_w_q > CTHR;
  assign dn_big   = dn_w_q > CTHR;
  assign settling = settle_q != '0;
  assign step_up  = !settling && up_big;
  assign step_dn  = !settling && !up_big && dn_big;

  assign ok_inc   = ok_q + 1'b1;
  assign good_inc = good_q + 1'b1;
  assign bad_inc  = bad_q + 1'b1;
  assign to_inc   = to_q + 1'b1;

  // Input synchronisers, ref edge delay, start edge and eval strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_s1_q <= 1'b0;
      ref_s2_q <= 1'b0;
      ref_s3_q <= 1'b0;
      up_s1_q  <= 1'b0;
      up_s2_q  <= 1'b0;
      dn_s1_q  <= 1'b0;
      dn_s2_q  <= 1'b0;
      start_q  <= 1'b0;
      eval_q   <= 1'b0;
    end else begin
      ref_s1_q <= ref_in;
      ref_s2_q <= ref_s1_q;
      ref_s3_q <= ref_s2_q;
      up_s1_q  <= up;
      up_s2_q  <= up_s1_q;
      dn_s1_q  <= down;
      dn_s2_q  <= dn_s1_q;
      start_q  <= start;
      eval_q   <= bnd;
    end
  end

  // Saturating pulse-width counters, latched and restarted per ref period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_cnt_q <= '0;
      dn_cnt_q <= '0;
      up_w_q   <= '0;
      dn_w_q   <= '0;
    end else if (bnd) begin
      up_w_q   <= up_nxt;
      dn_w_q   <= dn_nxt;
      up_cnt_q <= '0;
      dn_cnt_q <= '0;
    end else begin
      up_cnt_q <= up_nxt;
      dn_cnt_q <= dn_nxt;
    end
  end

  // Acquisition sequencer next-state and reference watchdog
  always_comb begin
    state_d  = state_q;
    band_d   = band_q;
    sat_d    = sat_q;
    settle_d = settle_q;
    ok_d     = ok_q;
    good_d   = good_q;
    bad_d    = bad_q;
    to_d     = '0;
    unlock_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_FAULT: begin
        if (start_rise) begin
          state_d  = S_COARSE;
          band_d   = BAND_RST;
          sat_d    = 1'b0;
          settle_d = '0;
          ok_d     = '0;
        end
      end
      S_COARSE: begin
        if (eval_q) begin
          unique case (1'b1)
            settling: begin
              settle_d = settle_q - 1'b1;
            end
            step_up: begin
              if (band_q == BAND_MAX) sat_d = 1'b1;
              else band_d = band_q + 1'b1;
              settle_d = SET_V;
              ok_d     = '0;
            end
            step_dn: begin
              if (band_q == '0) sat_d = 1'b1;
              else band_d = band_q - 1'b1;
              settle_d = SET_V;
              ok_d     = '0;
            end
            default: begin
              if (ok_inc == OK_V) begin
                state_d = S_FINE;
                ok_d    = '0;
                good_d  = '0;
              end else begin
                ok_d = ok_inc;
              end
            end
          endcase
        end
      end
      S_FINE: begin
        if (eval_q) begin
          if (err <= LTHR) begin
            if (good_inc == GOOD_V) begin
              state_d = S_LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      S_LOCKED: begin
        if (eval_q) begin
          if (err > UTHR) begin
            if (bad_inc == BAD_V) begin
              state_d  = S_COARSE;
              settle_d = SET_V;
              ok_d     = '0;
              bad_d    = '0;
              unlock_d = 1'b1;
            end else begin
              bad_d = bad_inc;
            end
          end else begin
            bad_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (active) begin
      if (bnd) to_d = '0;
      else if (to_inc == TO_V) state_d = S_FAULT;
      else to_d = to_inc;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      band_q   <= BAND_RST;
      sat_q    <= 1'b0;
      settle_q <= '0;
      ok_q     <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      to_q     <= '0;
      unlock_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      band_q   <= band_d;
      sat_q    <= sat_d;
      settle_q <= settle_d;
      ok_q     <= ok_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      to_q     <= to_d;
      unlock_q <= unlock_d;
    end
  end

`ifdef PLL_ACQ_STATS_EN
  logic [15:0]      llc_q;
  logic [CNT_W-1:0] lerr_q;

  // Lock-loss counter and most recent period error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      llc_q  <= '0;
      lerr_q <= '0;
    end else begin
      if (unlock_d && llc_q != 16'hFFFF) llc_q <= llc_q + 16'd1;
      if (eval_q && active) lerr_q <= err;
    end
  end

  assign lock_loss_cnt = llc_q;
  assign last_err      = lerr_q;
`endif

  assign band       = band_q;
  assign band_sat   = sat_q;
  assign unlock_evt = unlock_q;
  assign cp_en      = (state_q == S_FINE) || (state_q == S_LOCKED);
  assign lock       = state_q == S_LOCKED;
  assign fault      = state_q == S_FAULT;

endmodule

// File: tb/tb_pll_acq_ctrl.sv
// tb_pll_acq_ctrl: scoreboard bench for pll_acq_ctrl.
// Expected output-bundle changes are queued; a monitor pops on each change.
module tb_pll_acq_ctrl;

  localparam int HALF = 70;
  localparam int TMO  = 65535;
  localparam int PER  = 2 * HALF;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start;
  logic       ref_in;
  logic       up;
  logic       down;
  logic [3:0] band;
  logic       cp_en;
  logic       lock;
  logic       unlock_evt;
  logic       band_sat;
  logic       fault;
  logic [15:0] llc_obs;

`ifdef PLL_ACQ_STATS_EN
  logic [15:0] lock_loss_cnt;
  logic [11:0] last_err;
  assign llc_obs = lock_loss_cnt;
`else
  assign llc_obs = 16'h0;
`endif

  pll_acq_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .ref_in        (ref_in),
    .up            (up),
    .down          (down),
    .band          (band),
    .cp_en         (cp_en),
    .lock          (lock),
    .unlock_evt    (unlock_evt),
    .band_sat      (band_sat),
`ifdef PLL_ACQ_STATS_EN
    .lock_loss_cnt (lock_loss_cnt),
    .last_err      (last_err),
`endif
    .fault         (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [24:0] val;
    int          dcyc;
    bit          at_rst;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [24:0] mk(input int b, input bit cp,
                                     input bit lk, input bit ue,
                                     input bit sat, input bit flt,
                                     input int llc);
    logic [15:0] l;
    l = 16'(llc);
`ifndef PLL_ACQ_STATS_EN
    l = 16'h0;
`endif
    return {4'(b), cp, lk, ue, sat, flt, l};
  endfunction

  task automatic push(input string nm, input logic [24:0] v,
                      input int dc, input bit ar);
    exp_t e;
    e.name   = nm;
    e.val    = v;
    e.dcyc   = dc;
    e.at_rst = ar;
    q.push_back(e);
  endtask

  task automatic period(input int u, input int d);
    ref_in = 1'b0;
    for (int c = 0; c < HALF; c++) begin
      up   = (c >= 2) && (c < 2 + u);
      down = (c >= 2) && (c < 2 + d);
      @(posedge clk); #1;
    end
    up     = 1'b0;
    down   = 1'b0;
    ref_in = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic async_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Monitor: any change of the output bundle pops and checks one entry
  initial begin : mon
    logic [24:0] cur;
    logic [24:0] prev;
    int          cyc;
    int          last_cyc;
    bit          is_rst;
    exp_t        e;
    prev     = 'x;
    cyc      = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk or negedge reset_n);
      is_rst = (clk === 1'b1);
      if (!is_rst) cyc++;
      #1;
      cur = {band, cp_en, lock, unlock_evt, band_sat, fault, llc_obs};
      if (cur !== prev) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change act=%h required=none", cur);
        end else begin
          e = q.pop_front();
          if (cur !== e.val) begin
            n_fail++;
            $display("FAIL %s act=%h required=%h", e.name, cur, e.val);
          end else if (e.dcyc != 0 && cyc - last_cyc != e.dcyc) begin
            n_fail++;
            $display("FAIL %s_timing act=%0d required=%0d cycles",
                     e.name, cyc - last_cyc, e.dcyc);
          end else if (e.at_rst && !is_rst) begin
            n_fail++;
            $display("FAIL %s_async act=clocked required=immediate",
                     e.name);
          end
        end
        prev     = cur;
        last_cyc = cyc;
      end
    end
  end

  // Stimulus
  initial begin
    start  = 1'b0;
    ref_in = 1'b0;
    up     = 1'b0;
    down   = 1'b0;
    push("reset", mk(8, 0, 0, 0, 0, 0, 0), 0, 0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_pulse();

    push("band9", mk(9, 0, 0, 0, 0, 0, 0), 0, 0);
    push("band10", mk(10, 0, 0, 0, 0, 0, 0), 5 * PER, 0);
    repeat (6) period(66, 0);

    push("fine", mk(10, 1, 0, 0, 0, 0, 0), 0, 0);
    push("lock", mk(10, 1, 1, 0, 0, 0, 0), 16 * PER, 0);
    repeat (4) period(64, 64);
    repeat (3) period(64, 0);
    repeat (16) period(4, 3);

    push("unlock1", mk(10, 0, 0, 1, 0, 0, 1), 0, 0);
    push("unlock1_end", mk(10, 0, 0, 0, 0, 0, 1), 1, 0);
    repeat (3) period(0, 20);
    period(16, 0);
    repeat (4) period(0, 20);

    push("refine", mk(10, 1, 0, 0, 0, 0, 1), 0, 0);
    push("relock", mk(10, 1, 1, 0, 0, 0, 1), 16 * PER, 0);
    repeat (23) period(2, 2);
    push("unlock2", mk(10, 0, 0, 1, 0, 0, 2), 0, 0);
    push("unlock2_end", mk(10, 0, 0, 0, 0, 0, 2), 1, 0);
    repeat (4) period(0, 20);

    for (int b = 11; b <= 15; b++)
      push($sformatf("band%0d", b), mk(b, 0, 0, 0, 0, 0, 2),
           (b == 11) ? 0 : 5 * PER, 0);
    push("sat_hi", mk(15, 0, 0, 0, 1, 0, 2), 5 * PER, 0);
    repeat (30) period(66, 0);

    push("reset2", mk(8, 0, 0, 0, 0, 0, 0), 0, 1);
    async_reset();
    start_pulse();
    for (int b = 7; b >= 0; b--)
      push($sformatf("band%0d", b), mk(b, 0, 0, 0, 0, 0, 0),
           (b == 7) ? 0 : 5 * PER, 0);
    push("sat_lo", mk(0, 0, 0, 0, 1, 0, 0), 5 * PER, 0);
    repeat (41) period(0, 66);

    push("fine3", mk(0, 1, 0, 0, 1, 0, 0), 0, 0);
    repeat (7) period(2, 2);
    push("fault", mk(0, 0, 0, 0, 1, 1, 0), 0, 0);
    repeat (TMO + 200) @(posedge clk);
    #1;
    push("restart", mk(8, 0, 0, 0, 0, 0, 0), 0, 0);
    start_pulse();

    push("fine4", mk(8, 1, 0, 0, 0, 0, 0), 0, 0);
    push("lock4", mk(8, 1, 1, 0, 0, 0, 0), 16 * PER, 0);
    repeat (19) period(2, 2);

    push("reset3", mk(8, 0, 0, 0, 0, 0, 0), 0, 1);
    async_reset();

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending act=%0d required=0 (next %s)",
               q.size(), q[0].name);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
